// File: rtl/multiword_add_sequencer_if.sv
// Handshake and data bundle for multiword_add_sequencer: operand intake, result
// delivery and the busy status.
interface multiword_add_sequencer_if #(
  parameter int TW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          c_in;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          c_out;
  logic          busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Wide adder that walks a single W-bit carry-lookahead adder across WORDS words,
// least-significant word first, chaining the carry between words.
module carrylookahead_adder #(
  parameter int N      = 4,
  parameter int LEVELS = 2
) (
  input  logic [N**LEVELS-1:0] a,
  input  logic [N**LEVELS-1:0] b,
  input  logic                 c_in,
  output logic [N**LEVELS-1:0] sum,
  output logic                 c_out
);
  localparam int W  = N**LEVELS;
  localparam int NG = W / N;

  logic [W-1:0]  g_s;
  logic [W-1:0]  p_s;
  logic [W:0]    c_s;
  logic [NG:0]   gc_s;
  logic [NG-1:0] grp_g_s;
  logic [NG-1:0] grp_p_s;

  assign g_s   = a & b;
  assign p_s   = a ^ b;
  assign sum   = p_s ^ c_s[W-1:0];
  assign c_out = c_s[W];

  // Group generate/propagate, carries across groups, then bit carries inside each group.
  always_comb begin
    grp_g_s = '0;
    grp_p_s = '1;
    gc_s    = '0;
    c_s     = '0;
    gc_s[0] = c_in;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < N; k++) begin
        grp_g_s[j] = g_s[j*N+k] | (p_s[j*N+k] & grp_g_s[j]);
        grp_p_s[j] = grp_p_s[j] & p_s[j*N+k];
      end
      gc_s[j+1] = grp_g_s[j] | (grp_p_s[j] & gc_s[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c_s[j*N] = gc_s[j];
      for (int k = 0; k < N - 1; k++) begin
        c_s[j*N+k+1] = g_s[j*N+k] | (p_s[j*N+k] & c_s[j*N+k]);
      end
    end
    c_s[W] = gc_s[NG];
  end
endmodule

module multiword_add_sequencer #(
  parameter int N      = 4,
  parameter int LEVELS = 2,
  parameter int WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiword_add_sequencer_if.slave  bus
);
  localparam int W    = N**LEVELS;
  localparam int TW   = WORDS * W;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   a_r;
  logic [TW-1:0]   b_r;
  logic [TW-1:0]   sum_r;
  logic            carry_r;
  logic            c_out_r;
  logic [IDXW-1:0] idx_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;

  logic [W-1:0]    a_word_s;
  logic [W-1:0]    b_word_s;
  logic [W-1:0]    add_sum_s;
  logic            add_co_s;

  // Route the current word of each captured operand to the shared adder.
  always_comb begin
    a_word_s = '0;
    b_word_s = '0;
    for (int i = 0; i < WORDS; i++) begin
      a_word_s = a_word_s | ((idx_r == IDXW'(i)) ? a_r[i*W +: W] : {W{1'b0}});
      b_word_s = b_word_s | ((idx_r == IDXW'(i)) ? b_r[i*W +: W] : {W{1'b0}});
    end
  end

  carrylookahead_adder #(
    .N      (N),
    .LEVELS (LEVELS)
  ) u_cla (
    .a     (a_word_s),
    .b     (b_word_s),
    .c_in  (carry_r),
    .sum   (add_sum_s),
    .c_out (add_co_s)
  );

  // Sequencer FSM: capture operands, add one word per cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      c_out_r     <= 1'b0;
      idx_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry_r    <= bus.c_in;
            idx_r      <= '0;
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_r == IDXW'(i)) begin
              sum_r[i*W +: W] <= add_sum_s;
            end
          end
          carry_r <= add_co_s;
          if (idx_r == IDXW'(WORDS - 1)) begin
            state_r     <= DONE;
            c_out_r     <= add_co_s;
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (N=4, LEVELS=2, WORDS=4).
module tb_multiword_add_sequencer;
  localparam int WORDS = 4;
  localparam int TW    = 64;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multiword_add_sequencer_if #(.TW(TW)) bus_if ();

  multiword_add_sequencer #(
    .N      (4),
    .LEVELS (2),
    .WORDS  (WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [63:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a transaction and wait for out_valid; returns cycles after the accept edge.
  task automatic launch(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                        output int cycles);
    check("in_ready_before_accept", {64'd0, bus_if.in_ready}, 65'd1);
    bus_if.a        = ta;
    bus_if.b        = tb;
    bus_if.c_in     = tc;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.a        = {$urandom, $urandom};
    bus_if.b        = {$urandom, $urandom};
    bus_if.c_in     = 1'($urandom);
    cycles = 0;
    while (!bus_if.out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic finish_txn(input string name, input logic [63:0] es, input logic eco,
                            input int cycles, input int hold);
    check({name, "_latency"}, 65'(cycles), 65'(WORDS));
    check({name, "_sum"}, {1'b0, bus_if.sum}, {1'b0, es});
    check({name, "_c_out"}, {64'd0, bus_if.c_out}, {64'd0, eco});
    for (int i = 0; i < hold; i++) begin
      bus_if.in_valid = 1'($urandom);
      tick();
    end
    bus_if.in_valid  = 1'b0;
    check({name, "_held_sum"}, {bus_if.c_out, bus_if.sum}, {eco, es});
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check({name, "_ready_after"}, {63'd0, bus_if.in_ready, bus_if.out_valid}, 65'b10);
  endtask

  initial begin
    logic [64:0] ref_sum;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic [63:0] held_sum;
    logic        held_co;
    int          cyc;
    int          stable_bad;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[4] = '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0};
    vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 64'h0, 1'b1};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 64'h1, 1'b1};

    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.c_in      = 1'b0;
    rst_n            = 1'b0;
    #23;
    check("reset_flags", {62'd0, bus_if.in_ready, bus_if.out_valid, bus_if.busy}, 65'b100);
    check("reset_result", {bus_if.c_out, bus_if.sum}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].ci, cyc);
      finish_txn($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, cyc, i % 3);
    end

    // Stall in DONE with in_valid pressure; nothing may change or queue.
    launch(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, cyc);
    ref_sum  = {1'b0, 64'h1234_5678_9ABC_DEF0} + {1'b0, 64'h0FED_CBA9_8765_4321} + 65'd1;
    check("stall_latency", 65'(cyc), 65'(WORDS));
    held_sum   = bus_if.sum;
    held_co    = bus_if.c_out;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.a        = {$urandom, $urandom};
      bus_if.b        = {$urandom, $urandom};
      tick();
      if (!bus_if.out_valid || bus_if.in_ready || bus_if.sum !== held_sum || bus_if.c_out !== held_co)
        stable_bad++;
    end
    check("stall_result", {held_co, held_sum}, ref_sum);
    check("stall_stable", 65'(stable_bad), 65'd0);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check("stall_release", {63'd0, bus_if.in_ready, bus_if.out_valid}, 65'b10);
    stable_bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_if.out_valid || bus_if.busy) stable_bad++;
    end
    check("no_queued_result", 65'(stable_bad), 65'd0);

    // Reset while the third word is being added.
    bus_if.a        = 64'hAAAA_BBBB_CCCC_DDDD;
    bus_if.b        = 64'h1111_2222_3333_4444;
    bus_if.c_in     = 1'b0;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", {62'd0, bus_if.in_ready, bus_if.out_valid, bus_if.busy}, 65'b100);
    check("midrun_reset_sum", {bus_if.c_out, bus_if.sum}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(64'h5, 64'h3, 1'b0, cyc);
    finish_txn("after_reset", 64'h8, 1'b0, cyc, 0);

    // Randomized transactions against plain 65-bit arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if (i % 5 == 0) rb = ~ra;
      ref_sum = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      launch(ra, rb, rc, cyc);
      finish_txn($sformatf("rand%0d", i), ref_sum[63:0], ref_sum[64], cyc, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
